// File: rtl/htu_pkg.sv
// Shared encodings and address field bounds for the bank hit/tag unit front end.
package htu_pkg;

    localparam logic [1:0] HTU_OP_READ       = 2'd0;
    localparam logic [1:0] HTU_OP_WRITE      = 2'd1;
    localparam logic [1:0] HTU_OP_FLUSH      = 2'd2;
    localparam logic [1:0] HTU_OP_INVALIDATE = 2'd3;

    // Request addresses carry bits [31:5]; ADDR_LSB rebases byte-address bit numbers.
    localparam int TAG_MSB  = 31;
    localparam int TAG_LSB  = 10;
    localparam int IDX_LSB  = 6;
    localparam int OFF_BIT  = 5;
    localparam int ADDR_LSB = 5;
    localparam int ADDR_W   = TAG_MSB - ADDR_LSB + 1;
    localparam int TAG_W    = TAG_MSB - TAG_LSB + 1;

    localparam int STATE_W  = 2;
    localparam int WAY_W    = 3;

    // Flush and invalidate are maintenance ops that bypass the refill-busy check.
    function automatic logic op_is_maint(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/bank_htu_arb_if.sv
// Request/response handshake bundle between the two requesters and the HTU scheduler.
interface bank_htu_arb_if #(
    parameter int IDX_W = 4
);
    import htu_pkg::*;

    logic                   req0_valid_i;
    logic                   req0_ready_o;
    logic [1:0]             req0_op_i;
    logic [ADDR_W-1:0]      req0_addr_i;

    logic                   req1_valid_i;
    logic                   req1_ready_o;
    logic [1:0]             req1_op_i;
    logic [ADDR_W-1:0]      req1_addr_i;

    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic                   rsp_src_o;
    logic [1:0]             rsp_op_o;
    logic                   rsp_hit_o;
    logic [WAY_W-1:0]       rsp_way_o;
    logic [2*STATE_W-1:0]   rsp_state_o;
    logic [IDX_W-1:0]       rsp_set_o;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_addr_i,
        input  req1_valid_i, req1_op_i, req1_addr_i,
        input  rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output rsp_valid_o, rsp_src_o, rsp_op_o, rsp_hit_o, rsp_way_o, rsp_state_o, rsp_set_o
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_addr_i,
        output req1_valid_i, req1_op_i, req1_addr_i,
        output rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp_valid_o, rsp_src_o, rsp_op_o, rsp_hit_o, rsp_way_o, rsp_state_o, rsp_set_o
    );

endinterface

// File: rtl/bank_htu_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both sides compete.
module bank_htu_rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic ptr_reg;
    logic ptr_next;

    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        if (&eligible) begin
            grant[ptr_reg] = 1'b1;
            ptr_next       = !ptr_reg;
        end else begin
            grant = eligible;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/bank_htu_arb.sv
// HTU front-end scheduler: arbitrates core and maintenance lookups, strobes the addressed
// set, and buffers the selected set's result in a one-deep response slot.
module bank_htu_arb
    import htu_pkg::*;
#(
    parameter int SET_NUM = 16,
    parameter int IDX_W   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    bank_htu_arb_if.slave           bus,
    output logic [SET_NUM-1:0]      set_hit_WV_o,
    output logic                    op_is_read_o,
    output logic                    op_is_write_o,
    output logic                    op_is_flush_o,
    output logic                    op_is_invalidate_o,
    output logic [TAG_W-1:0]        access_tag_o,
    output logic                    access_offset_o,
    input  logic [SET_NUM-1:0]      set_cacheline_hit_i,
    input  logic [2*SET_NUM-1:0]    set_offset0_state_i,
    input  logic [2*SET_NUM-1:0]    set_offset1_state_i,
    input  logic [3*SET_NUM-1:0]    set_way_i,
    input  logic                    refill_done_i,
    input  logic [IDX_W-1:0]        refill_set_i
);

    localparam int IDX_LO = IDX_LSB - ADDR_LSB;

    logic [1:0]                     req_valid;
    logic [1:0][1:0]                req_op;
    logic [1:0][ADDR_W-1:0]         req_addr;
    logic [1:0][IDX_W-1:0]          req_idx;
    logic [1:0]                     eligible;
    logic [1:0]                     grant;
    logic                           slot_free;

    logic                           gnt_any;
    logic                           gnt_sel;
    logic [1:0]                     gnt_op;
    logic [ADDR_W-1:0]              gnt_addr;
    logic [IDX_W-1:0]               gnt_idx;

    logic [STATE_W-1:0]             state0_arr [SET_NUM];
    logic [STATE_W-1:0]             state1_arr [SET_NUM];
    logic [WAY_W-1:0]               way_arr    [SET_NUM];
    logic                           sel_hit;

    logic [SET_NUM-1:0]             busy_reg;
    logic [SET_NUM-1:0]             busy_next;

    logic                           rsp_valid_reg;
    logic                           rsp_src_reg;
    logic [1:0]                     rsp_op_reg;
    logic                           rsp_hit_reg;
    logic [WAY_W-1:0]               rsp_way_reg;
    logic [2*STATE_W-1:0]           rsp_state_reg;
    logic [IDX_W-1:0]               rsp_set_reg;

    assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};
    assign req_op    = {bus.req1_op_i, bus.req0_op_i};
    assign req_addr  = {bus.req1_addr_i, bus.req0_addr_i};
    assign slot_free = !rsp_valid_reg || bus.rsp_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_idx[gi]  = req_addr[gi][IDX_LO +: IDX_W];
            // Held off during reset so the strobe and readies stay quiet in that cycle.
            assign eligible[gi] = !rst_i && slot_free && req_valid[gi]
                                  && (op_is_maint(req_op[gi]) || !busy_reg[req_idx[gi]]);
        end
    endgenerate

    bank_htu_rr_arb2 u_rr (
        .clk      (clk_i),
        .srst     (rst_i),
        .eligible (eligible),
        .grant    (grant)
    );

    assign gnt_any  = |grant;
    assign gnt_sel  = grant[1];
    assign gnt_op   = req_op[gnt_sel];
    assign gnt_addr = req_addr[gnt_sel];
    assign gnt_idx  = req_idx[gnt_sel];

    assign bus.req0_ready_o = grant[0];
    assign bus.req1_ready_o = grant[1];

    generate
        for (gi = 0; gi < SET_NUM; gi++) begin : g_set
            assign set_hit_WV_o[gi] = gnt_any && (gnt_idx == IDX_W'(gi));
            assign state0_arr[gi]   = set_offset0_state_i[STATE_W*gi +: STATE_W];
            assign state1_arr[gi]   = set_offset1_state_i[STATE_W*gi +: STATE_W];
            assign way_arr[gi]      = set_way_i[WAY_W*gi +: WAY_W];
        end
    endgenerate

    assign sel_hit            = set_cacheline_hit_i[gnt_idx];
    assign op_is_read_o       = gnt_any && (gnt_op == HTU_OP_READ);
    assign op_is_write_o      = gnt_any && (gnt_op == HTU_OP_WRITE);
    assign op_is_flush_o      = gnt_any && (gnt_op == HTU_OP_FLUSH);
    assign op_is_invalidate_o = gnt_any && (gnt_op == HTU_OP_INVALIDATE);
    assign access_tag_o       = gnt_addr[ADDR_W-1 -: TAG_W];
    assign access_offset_o    = gnt_addr[OFF_BIT - ADDR_LSB];

    // Clear is applied first so a same-index miss in the same cycle leaves the set busy.
    always_comb begin
        busy_next = busy_reg;
        if (refill_done_i) begin
            busy_next[refill_set_i] = 1'b0;
        end
        if (gnt_any && !op_is_maint(gnt_op) && !sel_hit) begin
            busy_next[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_src_reg   <= 1'b0;
            rsp_op_reg    <= '0;
            rsp_hit_reg   <= 1'b0;
            rsp_way_reg   <= '0;
            rsp_state_reg <= '0;
            rsp_set_reg   <= '0;
        end else begin
            busy_reg <= busy_next;
            if (gnt_any) begin
                rsp_valid_reg <= 1'b1;
                rsp_src_reg   <= gnt_sel;
                rsp_op_reg    <= gnt_op;
                rsp_hit_reg   <= sel_hit;
                rsp_way_reg   <= way_arr[gnt_idx];
                rsp_state_reg <= {state1_arr[gnt_idx], state0_arr[gnt_idx]};
                rsp_set_reg   <= gnt_idx;
            end else if (rsp_valid_reg && bus.rsp_ready_i) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid_o = rsp_valid_reg;
    assign bus.rsp_src_o   = rsp_src_reg;
    assign bus.rsp_op_o    = rsp_op_reg;
    assign bus.rsp_hit_o   = rsp_hit_reg;
    assign bus.rsp_way_o   = rsp_way_reg;
    assign bus.rsp_state_o = rsp_state_reg;
    assign bus.rsp_set_o   = rsp_set_reg;

endmodule

// File: tb/tb_bank_htu_arb.sv
// Self-checking bench for bank_htu_arb: reference model of arbitration and busy tracking
// plus a response scoreboard, followed by directed scenarios and a random phase.
module tb_bank_htu_arb;
    import htu_pkg::*;

    localparam int SET_NUM = 16;
    localparam int IDX_W   = 4;

    typedef struct packed {
        logic       src;
        logic [1:0] op;
        logic       hit;
        logic [2:0] way;
        logic [3:0] state;
        logic [3:0] set;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bank_htu_arb_if #(.IDX_W(IDX_W)) bus ();

    logic [SET_NUM-1:0]   set_hit_wv;
    logic                 op_rd, op_wr, op_fl, op_inv;
    logic [TAG_W-1:0]     acc_tag;
    logic                 acc_off;
    logic [SET_NUM-1:0]   set_cl_hit;
    logic [2*SET_NUM-1:0] set_s0, set_s1;
    logic [3*SET_NUM-1:0] set_way;
    logic                 refill_done;
    logic [IDX_W-1:0]     refill_set;

    logic       tb_hit [SET_NUM];
    logic [2:0] tb_way [SET_NUM];
    logic [1:0] tb_s0  [SET_NUM];
    logic [1:0] tb_s1  [SET_NUM];

    always_comb begin
        set_cl_hit = '0;
        set_s0     = '0;
        set_s1     = '0;
        set_way    = '0;
        for (int s = 0; s < SET_NUM; s++) begin
            set_cl_hit[s]     = tb_hit[s];
            set_s0[2*s +: 2]  = tb_s0[s];
            set_s1[2*s +: 2]  = tb_s1[s];
            set_way[3*s +: 3] = tb_way[s];
        end
    end

    bank_htu_arb #(.SET_NUM(SET_NUM), .IDX_W(IDX_W)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .bus                 (bus),
        .set_hit_WV_o        (set_hit_wv),
        .op_is_read_o        (op_rd),
        .op_is_write_o       (op_wr),
        .op_is_flush_o       (op_fl),
        .op_is_invalidate_o  (op_inv),
        .access_tag_o        (acc_tag),
        .access_offset_o     (acc_off),
        .set_cacheline_hit_i (set_cl_hit),
        .set_offset0_state_i (set_s0),
        .set_offset1_state_i (set_s1),
        .set_way_i           (set_way),
        .refill_done_i       (refill_done),
        .refill_set_i        (refill_set)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic          m_ptr;
    logic [15:0]   m_busy;
    logic          m_rsp_valid;
    rsp_t          exp_q [$];
    int            p_win;
    logic          p_both;
    rsp_t          p_exp;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [26:0] mk_addr(input logic [21:0] t, input logic [3:0] idx, input logic off);
        return {t, idx, off};
    endfunction

    task automatic drive_req(input int port, input logic v, input logic [1:0] op, input logic [3:0] idx);
        logic [21:0] t;
        logic        o;
        t = 22'($urandom);
        o = 1'($urandom);
        if (port == 0) begin
            bus.req0_valid_i = v;
            bus.req0_op_i    = op;
            bus.req0_addr_i  = mk_addr(t, idx, o);
        end else begin
            bus.req1_valid_i = v;
            bus.req1_op_i    = op;
            bus.req1_addr_i  = mk_addr(t, idx, o);
        end
    endtask

    // Falling-edge check of all combinational grant outputs and the buffered response.
    task automatic sample();
        logic        slot, e0, e1;
        logic [3:0]  i0, i1, wi;
        logic [15:0] exp_strobe;
        logic [1:0]  wop;
        logic [26:0] waddr;
        @(negedge clk);
        i0   = bus.req0_addr_i[4:1];
        i1   = bus.req1_addr_i[4:1];
        slot = !m_rsp_valid || bus.rsp_ready_i;
        e0   = !rst && bus.req0_valid_i && slot && (bus.req0_op_i[1] || !m_busy[i0]);
        e1   = !rst && bus.req1_valid_i && slot && (bus.req1_op_i[1] || !m_busy[i1]);
        p_both = e0 && e1;
        if (e0 && e1)  p_win = int'(m_ptr);
        else if (e0)   p_win = 0;
        else if (e1)   p_win = 1;
        else           p_win = -1;

        check_val("req0_ready", 32'(bus.req0_ready_o), 32'(p_win == 0));
        check_val("req1_ready", 32'(bus.req1_ready_o), 32'(p_win == 1));
        exp_strobe = '0;
        if (p_win >= 0) begin
            waddr = (p_win == 1) ? bus.req1_addr_i : bus.req0_addr_i;
            wop   = (p_win == 1) ? bus.req1_op_i : bus.req0_op_i;
            wi    = waddr[4:1];
            exp_strobe[wi] = 1'b1;
            p_exp = '{src: (p_win == 1), op: wop, hit: tb_hit[wi], way: tb_way[wi],
                      state: {tb_s1[wi], tb_s0[wi]}, set: wi};
            check_val("op_lines", 32'({op_rd, op_wr, op_fl, op_inv}), 32'(4'b1000 >> wop));
            check_val("tag_off", 32'({acc_tag, acc_off}), 32'({waddr[26:5], waddr[0]}));
        end else begin
            check_val("op_idle", 32'({op_rd, op_wr, op_fl, op_inv}), 32'd0);
        end
        check_val("set_strobe", 32'(set_hit_wv), 32'(exp_strobe));
        check_val("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_rsp_valid));
        if (m_rsp_valid && exp_q.size() > 0) begin
            check_val("rsp_fields",
                      32'({bus.rsp_src_o, bus.rsp_op_o, bus.rsp_hit_o, bus.rsp_way_o, bus.rsp_state_o, bus.rsp_set_o}),
                      32'(exp_q[0]));
        end
    endtask

    task automatic advance();
        if (rst) begin
            m_ptr       = 1'b0;
            m_busy      = '0;
            m_rsp_valid = 1'b0;
            exp_q.delete();
        end else begin
            if (m_rsp_valid && bus.rsp_ready_i) begin
                $display("rsp src=%0d op=%0d set=%0d hit=%0d way=%0d state=%b",
                         exp_q[0].src, exp_q[0].op, exp_q[0].set, exp_q[0].hit, exp_q[0].way, exp_q[0].state);
                void'(exp_q.pop_front());
                m_rsp_valid = 1'b0;
            end
            if (p_win >= 0) begin
                if (p_both) m_ptr = !m_ptr;
                exp_q.push_back(p_exp);
                m_rsp_valid = 1'b1;
            end
            if (refill_done) m_busy[refill_set] = 1'b0;
            if (p_win >= 0 && !p_exp.op[1] && !p_exp.hit) m_busy[p_exp.set] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        for (int s = 0; s < SET_NUM; s++) begin
            tb_hit[s] = 1'b1;
            tb_way[s] = 3'(s);
            tb_s0[s]  = 2'(s);
            tb_s1[s]  = 2'(s >> 2);
        end
        rst = 1'b1;
        refill_done = 1'b0;
        refill_set  = '0;
        bus.rsp_ready_i = 1'b1;
        drive_req(0, 1'b0, HTU_OP_READ, 4'd0);
        drive_req(1, 1'b0, HTU_OP_READ, 4'd0);
        m_ptr = 1'b0; m_busy = '0; m_rsp_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        cyc();
        sample();
        check_val("rst_fields", 32'({bus.rsp_src_o, bus.rsp_op_o, bus.rsp_hit_o, bus.rsp_way_o,
                                     bus.rsp_state_o, bus.rsp_set_o}), 32'd0);
        advance();
        rst = 1'b0;

        // Single read hit on set 3
        tb_hit[3] = 1'b1; tb_way[3] = 3'd5; tb_s0[3] = 2'b01; tb_s1[3] = 2'b10;
        drive_req(0, 1'b1, HTU_OP_READ, 4'd3);
        sample();
        check_val("t1_strobe", 32'(set_hit_wv), 32'h0008);
        check_val("t1_is_read", 32'(op_rd), 32'd1);
        advance();
        drive_req(0, 1'b0, HTU_OP_READ, 4'd3);
        sample();
        check_val("t1_rsp", 32'({bus.rsp_valid_o, bus.rsp_src_o, bus.rsp_hit_o, bus.rsp_way_o, bus.rsp_state_o}),
                  32'({1'b1, 1'b0, 1'b1, 3'd5, 4'b1001}));
        advance();

        // Contention: alternating winners
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                drive_req(0, 1'b1, HTU_OP_READ, 4'd1);
                drive_req(1, 1'b1, HTU_OP_READ, 4'd2);
            end else begin
                drive_req(0, 1'b0, HTU_OP_READ, 4'd1);
                drive_req(1, 1'b0, HTU_OP_READ, 4'd2);
            end
            sample();
            if (k < 4) check_val("t2_winner", 32'(bus.req1_ready_o), 32'(k % 2));
            if (k > 0) check_val("t2_rsp_src", 32'(bus.rsp_src_o), 32'((k - 1) % 2));
            advance();
        end

        // Miss blocking on set 7
        tb_hit[7] = 1'b0; tb_way[7] = 3'd2;
        drive_req(0, 1'b1, HTU_OP_WRITE, 4'd7);
        cyc();
        drive_req(0, 1'b1, HTU_OP_READ, 4'd7);
        drive_req(1, 1'b1, HTU_OP_READ, 4'd8);
        sample();
        check_val("t3_blocked", 32'({bus.req0_ready_o, bus.req1_ready_o}), 32'b01);
        advance();
        drive_req(1, 1'b0, HTU_OP_READ, 4'd8);
        refill_done = 1'b1; refill_set = 4'd7;
        sample();
        check_val("t3_refill_cyc", 32'(bus.req0_ready_o), 32'd0);
        advance();
        refill_done = 1'b0;
        sample();
        check_val("t3_after_refill", 32'(bus.req0_ready_o), 32'd1);
        advance();
        drive_req(0, 1'b0, HTU_OP_READ, 4'd7);

        // Flush bypasses busy set 7
        drive_req(1, 1'b1, HTU_OP_FLUSH, 4'd7);
        sample();
        check_val("t4_flush", 32'({bus.req1_ready_o, op_fl}), 32'b11);
        advance();

        // Backpressure holds the flush response
        bus.rsp_ready_i = 1'b0;
        drive_req(0, 1'b1, HTU_OP_READ, 4'd1);
        drive_req(1, 1'b1, HTU_OP_READ, 4'd2);
        for (int k = 0; k < 3; k++) begin
            sample();
            check_val("t5_held", 32'({bus.rsp_src_o, bus.rsp_op_o, bus.rsp_set_o}),
                      32'({1'b1, HTU_OP_FLUSH, 4'd7}));
            advance();
        end
        bus.rsp_ready_i = 1'b1;
        sample();
        check_val("t5_release", 32'(bus.req0_ready_o | bus.req1_ready_o), 32'd1);
        advance();
        drive_req(0, 1'b0, HTU_OP_READ, 4'd1);
        drive_req(1, 1'b0, HTU_OP_READ, 4'd2);
        bus.rsp_ready_i = 1'b0;
        cyc();

        // Reset with busy[7] set and a response pending
        drive_req(0, 1'b1, HTU_OP_READ, 4'd7);
        drive_req(1, 1'b1, HTU_OP_READ, 4'd8);
        rst = 1'b1;
        sample();
        check_val("t6_rst_strobe", 32'(set_hit_wv), 32'd0);
        advance();
        rst = 1'b0;
        bus.rsp_ready_i = 1'b1;
        sample();
        check_val("t6_post_rst", 32'({bus.rsp_valid_o, bus.req0_ready_o, set_hit_wv}),
                  32'({1'b0, 1'b1, 16'h0080}));
        advance();

        // Random traffic against the model
        for (int k = 0; k < 200; k++) begin
            drive_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            drive_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
            refill_done     = ($urandom_range(0, 2) == 0);
            refill_set      = 4'($urandom_range(0, 15));
            for (int s = 0; s < SET_NUM; s++) begin
                tb_hit[s] = 1'($urandom);
                tb_way[s] = 3'($urandom);
                tb_s0[s]  = 2'($urandom);
                tb_s1[s]  = 2'($urandom);
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bank_htu_arb.md
Name: bank_htu_arb

Overview:
- Front-end scheduler for the bank hit/tag unit (HTU): shares the per-set HTU lookup between two requesters, the core access port (req0) and the maintenance/snoop port (req1).
- Grants at most one lookup per cycle and drives the one-hot set strobe and op lines to every set entry.
- Selects the addressed set's hit/state/way results and registers them in a single-entry response buffer with valid/ready backpressure.
- Blocks further lookups to any set with an outstanding miss refill.

Parameters:
- SET_NUM, 16, number of HTU sets; index width is log2(SET_NUM), fixed 4 for the default.
- IDX_W, 4, set index width; address bits [6+IDX_W-1:6].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req0_valid_i  in  1  core request valid
- req0_ready_o  out  1  core request accepted this cycle
- req0_op_i  in  2  0 read, 1 write, 2 flush, 3 invalidate
- req0_addr_i  in  27  address [31:5]; tag [31:10], index [9:6], offset [5]
- req1_valid_i / req1_ready_o / req1_op_i / req1_addr_i  same as req0, maintenance port
- set_hit_WV_o  out  SET_NUM  one-hot set strobe, zero when nothing is granted
- op_is_read_o, op_is_write_o, op_is_flush_o, op_is_invalidate_o  out  1 each  decoded op of the granted request, all zero when idle
- access_tag_o  out  22  granted tag
- access_offset_o  out  1  granted offset bit
- set_cacheline_hit_i  in  SET_NUM  per-set hit flags
- set_offset0_state_i  in  2*SET_NUM  per-set offset0 states, set s at [2s+1:2s]
- set_offset1_state_i  in  2*SET_NUM  per-set offset1 states
- set_way_i  in  3*SET_NUM  per-set access way
- refill_done_i  in  1  refill completed
- refill_set_i  in  IDX_W  set index of the completed refill
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_src_o  out  1  0 = req0, 1 = req1
- rsp_op_o  out  2  op of the response
- rsp_hit_o  out  1  lookup hit
- rsp_way_o  out  3  hit way, or allocated way on miss
- rsp_state_o  out  4  {offset1_state, offset0_state}
- rsp_set_o  out  IDX_W  set index of the response

Behaviour:
- Reset is synchronous and active-high on rst_i, clocked by clk_i.
  - Reset clears rsp_valid_o and all rsp_* fields to 0, busy bitmap to 0, and the round-robin pointer to 0 (req0 preferred).
  - Reset mid-operation drops any buffered response. set_hit_WV_o is 0 in the reset cycle.
- Eligibility:
  - reqN is eligible when its valid is high, its set busy bit is clear, and the response slot can accept, i.e. (!rsp_valid_o | rsp_ready_i).
  - Flush and invalidate ignore the busy bit and are always eligible when the slot can accept.
- Arbitration is round-robin.
  - With both requesters eligible, the pointer side wins; the pointer then toggles to the loser.
  - With one requester eligible, it wins and the pointer is unchanged.
- Grant cycle (combinational, same cycle):
  - req_ready_o high for the winner only.
  - set_hit_WV_o[index] = 1; op lines, tag and offset taken from the winner.
  - Per-set result muxed by index.
- Response capture: on the grant cycle's clock edge the muxed pre-update state is registered into the response buffer and rsp_valid_o is set.
  - Latency is 1 cycle from grant to rsp_valid_o.
  - Without a new grant, rsp_valid_o clears on rsp_valid_o & rsp_ready_i.
- Busy bitmap:
  - A granted read or write with hit = 0 sets busy[index] at the edge.
  - refill_done_i clears busy[refill_set_i] at the edge.
  - A miss cannot be granted to a busy set, so set and clear on the same index in the same cycle cannot collide. If it occurs anyway, set wins.
  - refill_done_i on a non-busy set has no effect.
- Backpressure: with rsp_valid_o = 1 and rsp_ready_i = 0, no grant is issued, no ready is asserted, and the buffer holds stable.
- No same-set hazard: set-entry state updates at the grant edge, and the next grant sees the updated state.

Decomposition:
- Shared package htu_pkg:
  - op encoding constants (HTU_OP_READ=0, WRITE=1, FLUSH=2, INVALIDATE=3);
  - address field bounds (TAG_MSB=31, TAG_LSB=10, IDX_LSB=6, OFF_BIT=5);
  - state width 2 and way width 3.
- One sub-module, bank_htu_rr_arb2: the 2-way round-robin arbiter with pointer register; inputs eligible[1:0], outputs grant[1:0].

Test Plan:
- Single read hit: req0 read, addr set 3, set 3 hit = 1, way 5, state 2'b01/2'b10.
  - Response: set_hit_WV_o = 16'h0008 and op_is_read_o = 1 in the grant cycle.
  - Next cycle: rsp_valid_o = 1, src 0, hit 1, way 5, state 4'b1001.
- Contention: both ports valid with reads to sets 1 and 2 for 4 cycles, rsp_ready_i = 1.
  - Grants alternate req0, req1, req0, req1; rsp_src_o follows 0,1,0,1 one cycle later.
- Miss blocking:
  - req0 write misses set 7, so busy[7] = 1.
  - A subsequent req0 read to set 7 is held with req0_ready_o = 0, while a req1 read to set 8 is granted.
  - After refill_done_i with refill_set_i = 7, the req0 read is granted the next cycle.
- Flush bypasses busy: while set 7 is busy, a req1 flush to set 7 is granted immediately with op_is_flush_o = 1.
- Backpressure: with rsp_valid_o = 1 and rsp_ready_i = 0 for 3 cycles and both ports valid, there are no grants and rsp_* is stable.
  - When rsp_ready_i rises, a grant occurs in that same cycle and the new response appears on the next cycle.
- Reset mid-operation: assert rst_i while busy[7] = 1 and rsp_valid_o = 1.
  - Next cycle: rsp_valid_o = 0, busy cleared, and a set-7 read is granted immediately with req0 preferred.
